factor_judge: RTL and testbench
===============================

Name: factor_judge

Overview:
- Answer-checking end of the factorization game's input path.
- The digit-entry block produces a 6-digit BCD question and two 3-digit BCD factors entered by the player. This block consumes them on a start pulse.
- It converts the BCD values to binary, multiplies the factors with a sequential shift-add multiplier, and compares the product with the question.
- It reports CORRECT / WRONG / INVALID with a fixed latency, for the LED and display logic.

Parameters:
- MIN_FACTOR, 2: smallest factor value accepted; a factor below it is a trivial factorization and is judged WRONG.
- MUL_BITS, 10: binary width of each factor; 999 fits in 10 bits. Also sets the number of multiply iterations.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle request to judge the current inputs.
- QUESTION  in  24  six BCD digits; [23:20] is the most significant digit.
- ANS_A  in  12  factor A, three BCD digits; [11:8] is the MSD.
- ANS_B  in  12  factor B, three BCD digits, same layout.
- BUSY  out  1  high from START acceptance until the DONE cycle, exclusive of DONE.
- DONE  out  1  one-cycle pulse when the verdict becomes valid.
- CORRECT  out  1  held verdict: A*B == QUESTION and both factors >= MIN_FACTOR.
- WRONG  out  1  held verdict: valid digits, but the check failed.
- INVALID  out  1  held verdict: some nibble of QUESTION, ANS_A or ANS_B is greater than 9.
- PRODUCT  out  20  binary A*B, held; 998001 max fits in 20 bits.

Behaviour:
- Reset (RST=1 at an edge): state IDLE; BUSY, DONE, CORRECT, WRONG, INVALID and PRODUCT all 0. Reset overrides everything, including a simultaneous START and any operation in progress. An aborted check produces no DONE.
- States and transitions:
  - IDLE → CONV when START=1 at an edge. On that same edge:
    - QUESTION, ANS_A and ANS_B are latched.
    - CORRECT, WRONG, INVALID and PRODUCT are cleared.
    - BUSY is set.
    - The latched nibbles are checked; any nibble > 9 sets an internal invalid flag.
  - CONV, 6 cycles, digit index 0..5 from the MSD:
    - q_bin = q_bin*10 + qdigit[i].
    - On indices 3..5, a_bin = a_bin*10 + adigit[i-3] and b_bin likewise.
    - Multiply by 10 is done as (x<<3)+(x<<1).
    - Invalid nibbles are used as-is; the result is discarded later.
  - MUL, MUL_BITS cycles: shift-add with prod initialized to 0. Each cycle, if the b_bin LSB is 1 then prod += a_shift; then a_shift<<=1 and b_bin>>=1.
  - CMP, 1 cycle:
    - PRODUCT <= prod.
    - If invalid: INVALID=1, CORRECT=0, WRONG=0.
    - Else if prod==q_bin and a_bin>=MIN_FACTOR and b_bin>=MIN_FACTOR: CORRECT=1.
    - Else: WRONG=1.
    - DONE=1 and BUSY=0 on the same edge; next state IDLE.
- Latency: DONE is high in the cycle following the 17th rising edge after the edge that accepted START (1 + 6 + 10 = 17 edges at the default MUL_BITS). It is fixed regardless of data or invalidity.
- DONE falls after one cycle. Verdict outputs and PRODUCT hold until the next accepted START or reset.
- Exactly one of CORRECT/WRONG/INVALID is high after any DONE; all three are low while BUSY.
- START while BUSY is ignored, with no effect on the latched operands.
- START in the DONE cycle (state already IDLE) is accepted.
- Changes on the inputs after acceptance have no effect.
- Operand order is irrelevant: A=11,B=13 and A=13,B=11 give identical results.
- Arithmetic is unsigned, with no overflow in any register: q_bin is 20 bits, prod is 20 bits, a_shift is 20 bits.

Test Plan:
1. Basic correct: Q=24'h000143, A=12'h011, B=12'h013, START pulse.
   → BUSY for 17 cycles; DONE pulse at edge +17; CORRECT=1, PRODUCT=143; WRONG=INVALID=0 held for 20 further cycles.
2. Trivial and mismatch: A=12'h001, B=12'h143, Q=000143 → WRONG=1, PRODUCT=143. Then A=012, B=011, Q=000144 → WRONG=1, PRODUCT=132.
3. Maximum: Q=24'h998001, A=12'h999, B=12'h999 → CORRECT=1, PRODUCT=20'hF3A71.
4. Invalid digit: A=12'h01A, B=013, Q=000143 → DONE at +17 with INVALID=1, CORRECT=WRONG=0.
5. Busy and reset:
   - START again 3 cycles after the first → ignored; a single DONE at +17.
   - A new run with RST=1 at edge +5 → BUSY=0 and all outputs 0 from the next cycle; no DONE follows.
6. Back-to-back: START held high in the DONE cycle of case 1 with B=12'h012 → accepted. Verdicts clear the next cycle; second DONE reports WRONG=1, PRODUCT=132.

Source files
------------

// File: rtl/factor_judge.sv
// factor_judge: checks a player's two BCD factors against a six-digit BCD question.
// Converts the BCD operands to binary, multiplies them with a shift-add loop, and
// reports CORRECT / WRONG / INVALID after a fixed 17-edge latency.
module factor_judge #(
    parameter int unsigned MIN_FACTOR = 2,
    parameter int unsigned MUL_BITS   = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [23:0] QUESTION,
    input  logic [11:0] ANS_A,
    input  logic [11:0] ANS_B,
    output logic        BUSY,
    output logic        DONE,
    output logic        CORRECT,
    output logic        WRONG,
    output logic        INVALID,
    output logic [19:0] PRODUCT
);

    localparam int unsigned Q_W      = 20;
    localparam int unsigned P_W      = 20;
    localparam int unsigned CONV_CYC = 6;
    localparam int unsigned AB_FIRST = 3;
    localparam int unsigned CNT_MAX  = (MUL_BITS > CONV_CYC) ? MUL_BITS : CONV_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_MUL,
        S_CMP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_conv_last;
    logic                  w_mul_last;

    logic [CNT_W-1:0]      r_cnt;
    logic [23:0]           r_q_sr;
    logic [11:0]           r_a_sr;
    logic [11:0]           r_b_sr;
    logic                  r_invalid;
    logic [Q_W-1:0]        r_q_bin;
    logic [MUL_BITS-1:0]   r_a_bin;
    logic [MUL_BITS-1:0]   r_b_bin;
    logic [P_W-1:0]        r_a_shift;
    logic [MUL_BITS-1:0]   r_b_shift;
    logic [P_W-1:0]        r_prod;

    logic                  w_bad_nibble;
    logic                  w_ab_phase;
    logic [Q_W-1:0]        w_q_next;
    logic [MUL_BITS-1:0]   w_a_next;
    logic [MUL_BITS-1:0]   w_b_next;

    // Flags any non-decimal nibble on the inputs being accepted this cycle
    always_comb begin
        w_bad_nibble = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (QUESTION[4*i +: 4] > 4'd9) w_bad_nibble = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (ANS_A[4*i +: 4] > 4'd9) w_bad_nibble = 1'b1;
            if (ANS_B[4*i +: 4] > 4'd9) w_bad_nibble = 1'b1;
        end
    end

    // Decimal accumulate step: x*10 + digit, with x*10 as (x<<3)+(x<<1); MSD leads each shift register
    always_comb begin
        w_ab_phase = (r_cnt >= CNT_W'(AB_FIRST));
        w_q_next   = (r_q_bin << 3) + (r_q_bin << 1) + Q_W'(r_q_sr[23:20]);
        w_a_next   = (r_a_bin << 3) + (r_a_bin << 1) + MUL_BITS'(r_a_sr[11:8]);
        w_b_next   = (r_b_bin << 3) + (r_b_bin << 1) + MUL_BITS'(r_b_sr[11:8]);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_conv_last  = 1'b0;
        w_mul_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(CONV_CYC - 1)) begin
                    w_conv_last  = 1'b1;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_W'(MUL_BITS - 1)) begin
                    w_mul_last   = 1'b1;
                    w_state_next = S_CMP;
                end
            end
            S_CMP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, BCD conversion, shift-add multiply, verdict registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_q_sr    <= '0;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_invalid <= 1'b0;
            r_q_bin   <= '0;
            r_a_bin   <= '0;
            r_b_bin   <= '0;
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_prod    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            CORRECT   <= 1'b0;
            WRONG     <= 1'b0;
            INVALID   <= 1'b0;
            PRODUCT   <= '0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q_sr    <= QUESTION;
                        r_a_sr    <= ANS_A;
                        r_b_sr    <= ANS_B;
                        r_invalid <= w_bad_nibble;
                        r_q_bin   <= '0;
                        r_a_bin   <= '0;
                        r_b_bin   <= '0;
                        r_cnt     <= '0;
                        BUSY      <= 1'b1;
                        CORRECT   <= 1'b0;
                        WRONG     <= 1'b0;
                        INVALID   <= 1'b0;
                        PRODUCT   <= '0;
                    end
                end
                S_CONV: begin
                    r_q_bin <= w_q_next;
                    r_q_sr  <= r_q_sr << 4;
                    if (w_ab_phase) begin
                        r_a_bin <= w_a_next;
                        r_b_bin <= w_b_next;
                        r_a_sr  <= r_a_sr << 4;
                        r_b_sr  <= r_b_sr << 4;
                    end
                    if (w_conv_last) begin
                        // Last digit step also seeds the multiplier with the final factors
                        r_cnt     <= '0;
                        r_a_shift <= P_W'(w_a_next);
                        r_b_shift <= w_b_next;
                        r_prod    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MUL: begin
                    if (r_b_shift[0]) r_prod <= r_prod + r_a_shift;
                    r_a_shift <= r_a_shift << 1;
                    r_b_shift <= r_b_shift >> 1;
                    if (w_mul_last) r_cnt <= '0;
                    else            r_cnt <= r_cnt + CNT_W'(1);
                end
                S_CMP: begin
                    PRODUCT <= r_prod;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b1;
                    if (r_invalid) begin
                        INVALID <= 1'b1;
                    end else if ((r_prod == r_q_bin)
                                 && (r_a_bin >= MUL_BITS'(MIN_FACTOR))
                                 && (r_b_bin >= MUL_BITS'(MIN_FACTOR))) begin
                        CORRECT <= 1'b1;
                    end else begin
                        WRONG <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_factor_judge.sv
// Bench for factor_judge: scenario tasks with a queue of model-derived expected verdicts.
module tb_factor_judge;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [23:0] QUESTION;
    logic [11:0] ANS_A;
    logic [11:0] ANS_B;
    logic        BUSY;
    logic        DONE;
    logic        CORRECT;
    logic        WRONG;
    logic        INVALID;
    logic [19:0] PRODUCT;

    typedef struct packed {
        logic        c;
        logic        w;
        logic        i;
        logic [19:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    factor_judge dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .QUESTION (QUESTION),
        .ANS_A    (ANS_A),
        .ANS_B    (ANS_B),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CORRECT  (CORRECT),
        .WRONG    (WRONG),
        .INVALID  (INVALID),
        .PRODUCT  (PRODUCT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test expected end of test");
        $fatal(1);
    end

    // Decimal reference: value of each BCD operand, verdict by the game rules
    function automatic exp_t model(input logic [23:0] q, input logic [11:0] a, input logic [11:0] b);
        exp_t e;
        int   qv, av, bv;
        logic bad;
        bad = 1'b0; qv = 0; av = 0; bv = 0;
        for (int i = 5; i >= 0; i--) begin
            if (q[4*i +: 4] > 4'd9) bad = 1'b1;
            qv = qv * 10 + int'(q[4*i +: 4]);
        end
        for (int i = 2; i >= 0; i--) begin
            if (a[4*i +: 4] > 4'd9) bad = 1'b1;
            if (b[4*i +: 4] > 4'd9) bad = 1'b1;
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
        end
        e.p = 20'(av * bv);
        e.i = bad;
        e.c = !bad && (av * bv == qv) && (av >= 2) && (bv >= 2);
        e.w = !bad && !e.c;
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_start(input logic [23:0] q, input logic [11:0] a, input logic [11:0] b);
        QUESTION = q;
        ANS_A    = a;
        ANS_B    = b;
        START    = 1'b1;
        tick();
        START    = 1'b0;
    endtask

    // Waits for DONE from just after the accept edge; lat = edges elapsed, -1 on timeout
    task automatic wait_done(output int lat, output int busy_cyc, output int vbusy);
        lat = 0; busy_cyc = 0; vbusy = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_cyc++;
            if (CORRECT || WRONG || INVALID) vbusy++;
            tick();
            lat++;
        end
        if (!DONE) lat = -1;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b1;
        QUESTION = 24'h000143; ANS_A = 12'h011; ANS_B = 12'h013;
        tick();
        tick();
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY);
        end
        n_checks++;
        if ({DONE, CORRECT, WRONG, INVALID} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {DONE, CORRECT, WRONG, INVALID});
        end
        n_checks++;
        if (PRODUCT !== 20'd0) begin
            n_fail++; $display("FAIL reset_product: got %0d expected 0", PRODUCT);
        end
        RST = 1'b0; START = 1'b0;
        tick();
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat, bc, vb, errs;
        sb.push_back(model(24'h000143, 12'h011, 12'h013));
        drive_start(24'h000143, 12'h011, 12'h013);
        wait_done(lat, bc, vb);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d expected 17", lat); end
        n_checks++;
        if (bc !== 17) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 17", bc); end
        n_checks++;
        if (vb !== 0) begin n_fail++; $display("FAIL basic_verdict_while_busy: got %0d expected 0", vb); end
        e = sb.pop_front();
        n_checks++;
        if ({CORRECT, WRONG, INVALID} !== {e.c, e.w, e.i}) begin
            n_fail++; $display("FAIL basic_verdict: got %b expected %b", {CORRECT, WRONG, INVALID}, {e.c, e.w, e.i});
        end
        n_checks++;
        if (PRODUCT !== e.p) begin n_fail++; $display("FAIL basic_product: got %0d expected %0d", PRODUCT, e.p); end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if ({CORRECT, WRONG, INVALID, PRODUCT} !== {e.c, e.w, e.i, e.p}) errs++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) errs++;
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL basic_hold: got %0d bad cycles expected 0", errs); end
        // Swapped operand order must give the same answer
        sb.push_back(model(24'h000143, 12'h013, 12'h011));
        drive_start(24'h000143, 12'h013, 12'h011);
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if ({CORRECT, WRONG, INVALID, PRODUCT} !== {e.c, e.w, e.i, e.p}) begin
            n_fail++; $display("FAIL swap_result: got %b/%0d expected %b/%0d", {CORRECT, WRONG, INVALID}, PRODUCT, {e.c, e.w, e.i}, e.p);
        end
    endtask

    task automatic test_wrong();
        exp_t e;
        int   lat, bc, vb;
        logic [23:0] qs [3];
        logic [11:0] as [3];
        logic [11:0] bs [3];
        qs[0] = 24'h000143; as[0] = 12'h001; bs[0] = 12'h143;
        qs[1] = 24'h000144; as[1] = 12'h012; bs[1] = 12'h011;
        qs[2] = 24'h001000; as[2] = 12'h002; bs[2] = 12'h500;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(qs[k], as[k], bs[k]));
            drive_start(qs[k], as[k], bs[k]);
            wait_done(lat, bc, vb);
            e = sb.pop_front();
            n_checks++;
            if (lat !== 17) begin n_fail++; $display("FAIL wrong_latency[%0d]: got %0d expected 17", k, lat); end
            n_checks++;
            if ({CORRECT, WRONG, INVALID} !== {e.c, e.w, e.i}) begin
                n_fail++; $display("FAIL wrong_verdict[%0d]: got %b expected %b", k, {CORRECT, WRONG, INVALID}, {e.c, e.w, e.i});
            end
            n_checks++;
            if (PRODUCT !== e.p) begin n_fail++; $display("FAIL wrong_product[%0d]: got %0d expected %0d", k, PRODUCT, e.p); end
            tick();
        end
    endtask

    task automatic test_max();
        exp_t e;
        int   lat, bc, vb;
        sb.push_back(model(24'h998001, 12'h999, 12'h999));
        drive_start(24'h998001, 12'h999, 12'h999);
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if (PRODUCT !== 20'hF3A71) begin n_fail++; $display("FAIL max_product: got %h expected F3A71", PRODUCT); end
        n_checks++;
        if ({CORRECT, WRONG, INVALID} !== {e.c, e.w, e.i}) begin
            n_fail++; $display("FAIL max_verdict: got %b expected %b", {CORRECT, WRONG, INVALID}, {e.c, e.w, e.i});
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        int   lat, bc, vb;
        sb.push_back(model(24'h000143, 12'h01A, 12'h013));
        drive_start(24'h000143, 12'h01A, 12'h013);
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL invalid_latency: got %0d expected 17", lat); end
        n_checks++;
        if ({CORRECT, WRONG, INVALID} !== {e.c, e.w, e.i}) begin
            n_fail++; $display("FAIL invalid_verdict: got %b expected %b", {CORRECT, WRONG, INVALID}, {e.c, e.w, e.i});
        end
        // Invalid digit in the question only
        sb.push_back(model(24'h0001F3, 12'h011, 12'h013));
        drive_start(24'h0001F3, 12'h011, 12'h013);
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if ({CORRECT, WRONG, INVALID} !== {e.c, e.w, e.i}) begin
            n_fail++; $display("FAIL invalid_q_verdict: got %b expected %b", {CORRECT, WRONG, INVALID}, {e.c, e.w, e.i});
        end
    endtask

    task automatic test_busy();
        exp_t e;
        int   lat, bc, vb, dones;
        sb.push_back(model(24'h000143, 12'h011, 12'h013));
        drive_start(24'h000143, 12'h011, 12'h013);
        tick();
        tick();
        QUESTION = 24'h000144; ANS_A = 12'h012; ANS_B = 12'h012;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(lat, bc, vb);
        if (lat >= 0) lat = lat + 3;
        e = sb.pop_front();
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL busy_latency: got %0d expected 17", lat); end
        n_checks++;
        if ({CORRECT, WRONG, INVALID, PRODUCT} !== {e.c, e.w, e.i, e.p}) begin
            n_fail++; $display("FAIL busy_result: got %b/%0d expected %b/%0d", {CORRECT, WRONG, INVALID}, PRODUCT, {e.c, e.w, e.i}, e.p);
        end
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (DONE) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL busy_extra_done: got %0d expected 0", dones); end
    endtask

    task automatic test_abort();
        int dones;
        drive_start(24'h000143, 12'h011, 12'h013);
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({BUSY, DONE, CORRECT, WRONG, INVALID} !== 5'b00000) begin
            n_fail++; $display("FAIL abort_flags: got %b expected 00000", {BUSY, DONE, CORRECT, WRONG, INVALID});
        end
        n_checks++;
        if (PRODUCT !== 20'd0) begin n_fail++; $display("FAIL abort_product: got %0d expected 0", PRODUCT); end
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (DONE || BUSY) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dones); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat, bc, vb;
        sb.push_back(model(24'h000143, 12'h011, 12'h013));
        drive_start(24'h000143, 12'h011, 12'h013);
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if ({DONE, CORRECT, WRONG, INVALID} !== {1'b1, e.c, e.w, e.i}) begin
            n_fail++; $display("FAIL b2b_first: got %b expected %b", {DONE, CORRECT, WRONG, INVALID}, {1'b1, e.c, e.w, e.i});
        end
        // START in the DONE cycle is accepted
        sb.push_back(model(24'h000143, 12'h011, 12'h012));
        drive_start(24'h000143, 12'h011, 12'h012);
        n_checks++;
        if ({BUSY, DONE, CORRECT, WRONG, INVALID} !== 5'b10000) begin
            n_fail++; $display("FAIL b2b_accept: got %b expected 10000", {BUSY, DONE, CORRECT, WRONG, INVALID});
        end
        n_checks++;
        if (PRODUCT !== 20'd0) begin n_fail++; $display("FAIL b2b_product_clear: got %0d expected 0", PRODUCT); end
        wait_done(lat, bc, vb);
        e = sb.pop_front();
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 17", lat); end
        n_checks++;
        if ({CORRECT, WRONG, INVALID, PRODUCT} !== {e.c, e.w, e.i, e.p}) begin
            n_fail++; $display("FAIL b2b_second: got %b/%0d expected %b/%0d", {CORRECT, WRONG, INVALID}, PRODUCT, {e.c, e.w, e.i}, e.p);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        START    = 1'b0;
        QUESTION = '0;
        ANS_A    = '0;
        ANS_B    = '0;
        test_reset();
        test_basic();
        test_wrong();
        test_max();
        test_invalid();
        test_busy();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
